// File: rtl/stop_sequencer.sv
// STOP instruction sequencer: CGB speed-switch pause and low-power STOP wait with joypad wake.
// Optional feature: define STOP_DEBOUNCE_EN to require DEBOUNCE_CYCLES of stable low joypad before wake.
module stop_sequencer #(
    parameter int SWITCH_CYCLES   = 8200,
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       stop_req,
    input  logic       switch_pending,
    input  logic [3:0] joypad_n,
    output logic       stop,
    output logic       cpu_hold,
    output logic       div_reset,
    output logic       switch_done,
    output logic [1:0] state
);

    localparam int            CW      = $clog2(SWITCH_CYCLES + 1);
    localparam logic [CW-1:0] SW_LAST = CW'(SWITCH_CYCLES);
    localparam logic [CW-1:0] SW_PREV = CW'(SWITCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWITCH    = 2'd1,
        STOP_WAIT = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sw_cnt;
    logic          accept;
    logic          wake;

    // A plain STOP with a joypad line already low is dropped entirely.
    assign accept = (state_q == IDLE) && stop_req && cpu_en &&
                    (switch_pending || (joypad_n == 4'hF));

`ifdef STOP_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);

    logic [DW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            db_cnt <= '0;
        else if (state_q != STOP_WAIT || joypad_n == 4'hF)
            db_cnt <= '0;
        else if (db_cnt != DB_LAST)
            db_cnt <= db_cnt + DW'(1);
    end

    assign wake = (db_cnt == DB_LAST);
`else
    assign wake = (joypad_n != 4'hF);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = switch_pending ? SWITCH : STOP_WAIT;
            SWITCH:    if (sw_cnt == SW_LAST) state_d = RELEASE;
            STOP_WAIT: if (wake) state_d = RELEASE;
            RELEASE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: outputs are registered from state_d so they line up with the state register, not lag it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sw_cnt      <= '0;
            stop        <= 1'b0;
            cpu_hold    <= 1'b0;
            div_reset   <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop        <= (state_d == SWITCH) || (state_d == STOP_WAIT);
            cpu_hold    <= (state_d != IDLE);
            div_reset   <= accept;
            switch_done <= (state_q == SWITCH) && cpu_en && (sw_cnt == SW_PREV);
            if (state_q != SWITCH)
                sw_cnt <= '0;
            else if (cpu_en && sw_cnt != SW_LAST)
                sw_cnt <= sw_cnt + CW'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stop_sequencer.sv
// Self-checking bench for stop_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_stop_sequencer;

    logic       clk;
    logic       reset;
    logic       cpu_en;
    logic       stop_req;
    logic       switch_pending;
    logic [3:0] joypad_n;
    logic       stop;
    logic       cpu_hold;
    logic       div_reset;
    logic       switch_done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    stop_sequencer #(.SWITCH_CYCLES(16), .DEBOUNCE_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_en         (cpu_en),
        .stop_req       (stop_req),
        .switch_pending (switch_pending),
        .joypad_n       (joypad_n),
        .stop           (stop),
        .cpu_hold       (cpu_hold),
        .div_reset      (div_reset),
        .switch_done    (switch_done),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, en, req, sp;
        logic [3:0] joy;
        logic [5:0] exp;   // {stop, cpu_hold, div_reset, switch_done, state}
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, e, q, s, input logic [3:0] j);
        reset = r; cpu_en = e; stop_req = q; switch_pending = s; joypad_n = j;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {stop, cpu_hold, div_reset, switch_done, state};
    endfunction

    // Runs a switch already accepted on the previous edge and profiles its outputs.
    task automatic measure(input int cycles, input bit half,
                           output int stop_n, output int div_n, output int done_n,
                           output int done_i, output int rel_i);
        stop_n = 0; div_n = 0; done_n = 0; done_i = 0; rel_i = 0;
        for (int i = 1; i <= cycles; i++) begin
            cpu_en = half ? ((i % 2) == 0) : 1'b1;
            if (stop) stop_n++;
            if (div_reset) div_n++;
            if (switch_done) begin done_n++; done_i = i; end
            if (state == 2'd3 && !stop && cpu_hold) rel_i = i;
            step();
        end
        cpu_en = 1'b1;
    endtask

    int stop_n, div_n, done_n, done_i, rel_i, bad;

    initial begin
        drive(1, 1, 0, 0, 4'hF);

        vecs[0]  = '{1, 1, 0, 0, 4'hF, 6'b0000_00};
        vecs[1]  = '{0, 1, 0, 0, 4'hF, 6'b0000_00};
        vecs[2]  = '{0, 1, 1, 0, 4'h7, 6'b0000_00};   // joypad low: STOP ignored
        vecs[3]  = '{0, 0, 1, 1, 4'hF, 6'b0000_00};   // cpu_en low: request ignored
        vecs[4]  = '{0, 1, 1, 0, 4'hF, 6'b1110_10};
        vecs[5]  = '{0, 1, 0, 0, 4'hF, 6'b1100_10};
        vecs[6]  = '{0, 1, 1, 1, 4'hF, 6'b1100_10};   // stop_req outside IDLE ignored
`ifdef STOP_DEBOUNCE_EN
        vecs[7]  = '{0, 1, 0, 0, 4'hE, 6'b1100_10};
        vecs[8]  = '{0, 1, 0, 0, 4'hE, 6'b1100_10};
        vecs[9]  = '{0, 1, 1, 0, 4'hF, 6'b1100_10};
`else
        vecs[7]  = '{0, 1, 0, 0, 4'hE, 6'b0100_11};
        vecs[8]  = '{0, 1, 0, 0, 4'hE, 6'b0000_00};
        vecs[9]  = '{0, 1, 1, 0, 4'hF, 6'b1110_10};
`endif
        vecs[10] = '{1, 1, 0, 0, 4'hF, 6'b0000_00};
        vecs[11] = '{1, 1, 1, 1, 4'hF, 6'b0000_00};   // reset beats stop_req
        vecs[12] = '{0, 1, 0, 0, 4'hF, 6'b0000_00};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].sp, vecs[i].joy);
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Full-rate speed switch: 17 stop cycles, switch_done on the last, then one RELEASE.
        drive(0, 1, 1, 1, 4'hF);
        step();
        stop_req = 1'b0;
        measure(24, 1'b0, stop_n, div_n, done_n, done_i, rel_i);
        check("full_stop_len", stop_n, 17);
        check("full_div_pulses", div_n, 1);
        check("full_done_pulses", done_n, 1);
        check("full_done_cycle", done_i, 17);
        check("full_release_cycle", rel_i, 18);
        check("full_back_idle", {cpu_hold, state}, 3'b0_00);

        // Half rate: request with cpu_en low is dropped; switch then paced by alternate ticks.
        drive(0, 0, 1, 1, 4'hF);
        step();
        check("half_req_en0_ignored", {stop, div_reset, state}, 4'b0_0_00);
        drive(0, 1, 1, 1, 4'hF);
        step();
        stop_req = 1'b0;
        measure(50, 1'b1, stop_n, div_n, done_n, done_i, rel_i);
        // Entry cycle has cpu_en low, 16 ticks land on even cycles, then the terminal cycle.
        check("half_stop_len", stop_n, 33);
        check("half_done_cycle", done_i, 33);
        check("half_release_cycle", rel_i, 34);
        check("half_div_pulses", div_n, 1);

`ifdef STOP_DEBOUNCE_EN
        drive(0, 1, 1, 0, 4'hF);
        step();
        stop_req = 1'b0;
        joypad_n = 4'hE;
        repeat (5) step();
        joypad_n = 4'hF;
        step();
        check("deb_glitch_stays", {stop, state}, 3'b1_10);
        joypad_n = 4'hE;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) check("deb_k8_waiting", state, 2'd2);
            if (k == 9) check("deb_k9_release", {stop, cpu_hold, state}, 4'b0_1_11);
        end
        joypad_n = 4'hF;
        step();
        check("deb_idle", {cpu_hold, state}, 3'b0_00);
`else
        drive(0, 1, 1, 0, 4'hF);
        step();
        stop_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 98; i++) begin
            step();
            if (state != 2'd2 || !stop || !cpu_hold) bad++;
        end
        check("wait_holds", bad, 0);
        joypad_n = 4'hE;
        step();
        check("wake_release", {stop, cpu_hold, state}, 4'b0_1_11);
        step();
        check("wake_idle", {stop, cpu_hold, state}, 4'b0_0_00);
        joypad_n = 4'hF;
`endif

        // Reset at count 7 aborts the switch silently; a fresh request counts from zero.
        drive(0, 1, 1, 1, 4'hF);
        step();
        stop_req = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        check("rst_mid_switch", 32'(outs()), 32'd0);
        reset = 1'b0;
        done_n = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (switch_done) done_n++;
            if (state != 2'd0) bad++;
        end
        check("rst_no_done", done_n, 0);
        check("rst_stays_idle", bad, 0);
        drive(0, 1, 1, 1, 4'hF);
        step();
        stop_req = 1'b0;
        measure(24, 1'b0, stop_n, div_n, done_n, done_i, rel_i);
        check("restart_stop_len", stop_n, 17);
        check("restart_done_cycle", done_i, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
